// File: rtl/vcache_stat_trigger.sv
// Print-stat trigger for the vcache profilers: queues tagged requests and replays them
// as spaced single-cycle broadcast pulses alongside a free-running global cycle counter.
module vcache_stat_trigger #(
    parameter int data_width_p = 8,
    parameter int els_p        = 4,
    parameter int gap_p        = 2,
    parameter int ctr_width_p  = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [data_width_p-1:0] tag_i,
    output logic                    ready_o,
    output logic                    print_stat_v_o,
    output logic [data_width_p-1:0] print_stat_tag_o,
    output logic [ctr_width_p-1:0]  global_ctr_o,
    output logic [31:0]             issued_count_o,
    output logic                    busy_o
);
    localparam int ptr_w_lp = $clog2(els_p);
    localparam int gap_w_lp = (gap_p > 1) ? $clog2(gap_p) : 1;

    typedef enum logic [1:0] {IDLE, FIRE, GAP} state_e;

    state_e                  state_q, state_n;
    logic [gap_w_lp-1:0]     gap_q, gap_n;
    logic [ptr_w_lp:0]       wptr_q, rptr_q;
    logic [data_width_p-1:0] mem_q [els_p];
    logic                    full, empty, enq, deq;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp]) &&
                     (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);
    assign ready_o = ~full;
    assign enq     = v_i & ~full;
    assign busy_o  = ~empty | (state_q != IDLE);

    always_comb begin
        state_n = state_q;
        gap_n   = gap_q;
        deq     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_n = FIRE;
                    deq     = 1'b1;
                end
            end
            FIRE: begin
                if (gap_p != 0) begin
                    state_n = GAP;
                    gap_n   = gap_w_lp'(gap_p - 1);
                end else if (!empty) begin
                    state_n = FIRE;
                    deq     = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (!empty) begin
                        state_n = FIRE;
                        deq     = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_n;
            gap_q   <= gap_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (enq) wptr_q <= wptr_q + 1'b1;
            if (deq) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q[ptr_w_lp-1:0]] <= tag_i;
    end

    // Pulse, tag and issue count all update on the edge that enters FIRE.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            print_stat_v_o   <= 1'b0;
            print_stat_tag_o <= '0;
            issued_count_o   <= '0;
        end else begin
            print_stat_v_o <= deq;
            if (deq) begin
                print_stat_tag_o <= mem_q[rptr_q[ptr_w_lp-1:0]];
                issued_count_o   <= issued_count_o + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) global_ctr_o <= '0;
        else            global_ctr_o <= global_ctr_o + 1'b1;
    end

endmodule

// File: doc/vcache_stat_trigger.md
# vcache_stat_trigger

Generates the stat-print trigger stream, tag and global cycle count consumed by the per-vcache profilers. Accepts print-stat requests (one tag each) from the print-stat store decoder on a valid/ready interface and buffers them in a small FIFO. Replays them as single-cycle broadcast pulses with a guaranteed minimum spacing, so every vcache profiler samples the same pulse, tag and counter value. Sits at the testbench top level next to the vcache array; one instance drives all caches.

## Interface
- data_width_p, "inv": tag width; must equal the profilers' data width.
- els_p, 4: request FIFO depth; power of two, ≥2.
- gap_p, 2: minimum idle cycles between consecutive print pulses; 0 allowed.
- ctr_width_p, 32: global counter width; 32 in normal use, smaller for test only.
- Reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock; all state on posedge.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  1  print-stat request valid.
- tag_i  in  data_width_p  request tag; sampled with v_i.
- ready_o  out  1  FIFO can accept; a request is taken when v_i & ready_o at posedge.
- print_stat_v_o  out  1  single-cycle print pulse.
- print_stat_tag_o  out  data_width_p  tag of the current or most recent pulse.
- global_ctr_o  out  ctr_width_p  free-running cycle count.
- issued_count_o  out  32  number of pulses issued since reset.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Global counter: increments by 1 every posedge while reset is deasserted. Wraps from 2^ctr_width_p−1 to 0 with no flag.
- FIFO: els_p entries, head/tail pointers with one extra wrap bit.
  - full = pointers equal except the wrap bit; empty = pointers fully equal.
  - Enqueue on v_i & ready_o. ready_o = ~full, derived from registered pointers only, with no combinational path from v_i.
  - Dequeue happens only on entering FIRE.
  - Enqueue and dequeue in the same cycle are allowed when not full.
  - When full, ready_o stays low for that cycle even if a dequeue is occurring. ready_o rises the next cycle.
- FSM states are IDLE, FIRE and GAP.
  - IDLE: if FIFO non-empty → FIRE (dequeue head into the tag register). Otherwise stay in IDLE.
  - FIRE: print_stat_v_o=1 for exactly this cycle; issued_count increments. Next state is GAP with gap counter loaded to gap_p−1. If gap_p=0, next state is FIRE when the FIFO is non-empty (dequeue), else IDLE.
  - GAP: counter decrements each cycle. When it reaches 0, go to FIRE if the FIFO is non-empty, else IDLE.
- print_stat_tag_o is registered and updates on entry to FIRE. It holds until the next FIRE.
- There is no bypass: a request accepted into an empty FIFO is never pulsed in its acceptance cycle.
- issued_count_o wraps at 2^32.

## Timing
- Reset values (asynchronous, immediate on reset_n_i low):
  - print_stat_v_o=0, print_stat_tag_o=0, global_ctr_o=0, issued_count_o=0, busy_o=0.
  - ready_o=1, FIFO empty, FSM IDLE.
- Reset mid-operation: any pulse in progress drops in the same instant and queued tags are discarded. The first posedge after release increments global_ctr_o to 1.
- Latency: request accepted at posedge N with FSM IDLE → FSM enters FIRE at posedge N+1, so print_stat_v_o is high during cycle N+1 to N+2.
- Spacing: consecutive pulses have rising edges exactly gap_p+1 cycles apart when the FIFO stays non-empty.
- Pulse ordering matches acceptance order.
- Outputs are all registered, so profilers sampling on negedge see stable values.
- global_ctr_o is not frozen during a pulse. The value the profilers see is whatever it holds in the pulse cycle.
- busy_o falls in the first cycle with the FSM in IDLE and the FIFO empty.

## Test plan
- Reset check: hold reset_n_i low for 3 cycles → all outputs at their reset values, ready_o=1. Release → global_ctr_o reads 1, 2, 3 on successive posedges.
- Single request: tag_i=0xA5 accepted at posedge 10 → print_stat_v_o=1 only during cycle 11 with tag 0xA5; issued_count_o=1; busy_o low from cycle 12+gap_p.
- Burst: tags 1, 2, 3 on consecutive cycles, gap_p=2 → pulse rising edges 3 cycles apart, tags 1, 2, 3 in order, issued_count_o=3. Repeat with gap_p=0 → three back-to-back pulses.
- Backpressure: els_p=4, gap_p=8, v_i held high with tags 0..9 → ready_o drops after 5 acceptances (4 in FIFO plus 1 dequeued). No tag is lost or duplicated; all 10 are pulsed in order.
- Wrap: ctr_width_p=8, run 260 cycles → global_ctr_o goes 255 → 0 → 1. A pulse issued at the wrap reports 0.
- Async reset mid-GAP with 2 tags queued: assert reset_n_i between clock edges → outputs clear without waiting for an edge. After release, no pulse appears within 20 cycles.
